iomem_gpio: RTL and testbench
=============================

IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0000, 256-byte window base; bits [7:0] ignored.
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port iomem_valid  input  1  initiator request, held until iomem_ready.
REQ-005 SHALL have port iomem_ready  output  1  one-cycle acknowledge.
REQ-006 SHALL have port iomem_addr  input  32  byte address.
REQ-007 SHALL have port iomem_wdata  input  32  write data.
REQ-008 SHALL have port iomem_wstrb  input  4  byte write strobes; 0 = read.
REQ-009 SHALL have port iomem_rdata  output  32  read data.
REQ-010 SHALL have port gpio_in  input  32  asynchronous pin inputs.
REQ-011 SHALL have port gpio_out  output  32  pin output values.
REQ-012 SHALL have port gpio_oe  output  32  pin output enables, 1 = drive.
REQ-013 SHALL have port irq  output  1  level interrupt, registered.

Function
REQ-014 SHALL treat a request as selected when iomem_valid=1 and iomem_addr[31:8]=BASE_ADDR[31:8]; unselected requests SHALL be ignored, ready stays 0.
REQ-015 SHALL implement a two-state handshake FSM, IDLE and ACK: IDLE->ACK on a selected request; ACK->IDLE unconditionally.
REQ-016 SHALL drive iomem_ready=1 only in ACK, giving exactly one wait cycle: ready is asserted in the second cycle of valid.
REQ-017 SHALL never assert ready on two consecutive cycles; a request still valid in the cycle after ACK is a new transaction.
REQ-018 SHALL commit writes and capture read data on the IDLE->ACK edge; read data SHALL be the pre-write register value.
REQ-019 SHALL drive iomem_rdata with the captured value in ACK and 0 otherwise.
REQ-020 SHALL decode offset iomem_addr[7:2] as follows:
- 0x00 OUT: RW.
- 0x04 OE: RW.
- 0x08 IN: RO, synchronized pins.
- 0x0C IRQ_EN: RW.
- 0x10 IRQ_STAT: RW1C.
- 0x14 EDGE: RW, 1 = rising, 0 = falling.
- 0x18 OUT_SET: WO, write-1 sets OUT bits.
- 0x1C OUT_CLR: WO, write-1 clears OUT bits.
REQ-021 SHALL apply each iomem_wstrb[n] to bits [8n+7:8n] for every writable register, including the W1C, set and clear registers.
REQ-022 SHALL read 0 from OUT_SET, OUT_CLR and unmapped offsets; writes to IN and unmapped offsets SHALL be acknowledged with no effect.
REQ-023 SHALL drive gpio_out=OUT and gpio_oe=OE directly from registers.
REQ-024 SHALL synchronize gpio_in through two flops (s1, s2) and keep prev = s2 of the previous cycle; IN reads s2.
REQ-025 SHALL compute event[i] = EDGE[i] ? (s2&~prev) : (~s2&prev).
REQ-026 SHALL set IRQ_STAT[i] on event[i] regardless of IRQ_EN[i].
REQ-027 SHALL give set priority over a same-cycle W1C on the same bit.
REQ-028 SHALL register irq <= |(IRQ_STAT & IRQ_EN).
REQ-029 Latency: a pin change sampled at edge k SHALL set IRQ_STAT at edge k+2 and irq at edge k+3.
REQ-030 SHALL mask events with a 2-bit arm counter until two cycles after resetn deasserts, preventing spurious edges from reset values.

Reset
REQ-031 With resetn=0 at a clock edge, all of the following SHALL be 0: OUT, OE, IRQ_EN, IRQ_STAT, EDGE, s1, s2, prev, arm counter, irq, iomem_ready and iomem_rdata; FSM SHALL be IDLE.
REQ-032 Reset during ACK SHALL drop ready next cycle; a write whose commit edge coincides with reset SHALL be discarded.

Verification
REQ-033 Write OUT=0xA5A5_0000 with wstrb=4'b1100, then read OUT: ready high exactly on the 2nd valid cycle each time; gpio_out=0xA5A5_0000; rdata=0xA5A5_0000.
REQ-034 OUT=0x0000_00FF, write OUT_SET=0x100, then OUT_CLR=0x1: gpio_out=0x0000_01FE; reading OUT_SET returns 0.
REQ-035 EDGE=0, IRQ_EN=0x4; gpio_in[2] 1->0: IRQ_STAT=0x4 two edges after sampling, irq=1 one edge later; write IRQ_STAT=0x4 -> irq=0 two cycles later.
REQ-036 W1C of bit 0 issued in the same cycle as a new rising event on bit 0: IRQ_STAT[0] stays 1.
REQ-037 gpio_in=0xFFFF_FFFF held through reset, IRQ_EN=all ones after release: IRQ_STAT stays 0; irq stays 0.
REQ-038 Back-to-back requests, valid held 4 cycles at an unmapped offset: ready pattern 0,1,0,1; rdata=0.

Source files
------------

// File: rtl/iomem_gpio.sv
// Memory-mapped 32-bit GPIO block on the iomem bus: output/enable registers,
// synchronised pin inputs and per-pin edge interrupts with a one-wait-state handshake.
module iomem_gpio #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    input  logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_rdata,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_oe,
    output logic        irq
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    localparam logic [5:0] OFF_OUT      = 6'h00;
    localparam logic [5:0] OFF_OE       = 6'h01;
    localparam logic [5:0] OFF_IN       = 6'h02;
    localparam logic [5:0] OFF_IRQ_EN   = 6'h03;
    localparam logic [5:0] OFF_IRQ_STAT = 6'h04;
    localparam logic [5:0] OFF_EDGE     = 6'h05;
    localparam logic [5:0] OFF_OUT_SET  = 6'h06;
    localparam logic [5:0] OFF_OUT_CLR  = 6'h07;

    // Expand the byte strobes to a bit mask.
    function automatic logic [31:0] strobe_mask(input logic [3:0] strb);
        strobe_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

    state_t      state_r;
    logic [31:0] out_r;
    logic [31:0] oe_r;
    logic [31:0] irq_en_r;
    logic [31:0] irq_stat_r;
    logic [31:0] edge_r;
    logic [31:0] s1_r;
    logic [31:0] s2_r;
    logic [31:0] prev_r;
    logic [1:0]  arm_r;

    logic        sel_s;
    logic        wr_s;
    logic [5:0]  off_s;
    logic [31:0] wmask_s;
    logic [31:0] wbits_s;
    logic [31:0] rd_mux_s;
    logic [31:0] event_s;
    logic [31:0] out_nxt_s;
    logic [31:0] stat_nxt_s;

    assign gpio_out = out_r;
    assign gpio_oe  = oe_r;

    // Request decode; writes only commit on the IDLE->ACK edge.
    always_comb begin
        sel_s   = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
        wr_s    = sel_s && (state_r == ST_IDLE) && (iomem_wstrb != 4'b0000);
        off_s   = iomem_addr[7:2];
        wmask_s = strobe_mask(iomem_wstrb);
        wbits_s = iomem_wdata & wmask_s;
    end

    // Read multiplexer over the current (pre-write) register values.
    always_comb begin
        case (off_s)
            OFF_OUT:      rd_mux_s = out_r;
            OFF_OE:       rd_mux_s = oe_r;
            OFF_IN:       rd_mux_s = s2_r;
            OFF_IRQ_EN:   rd_mux_s = irq_en_r;
            OFF_IRQ_STAT: rd_mux_s = irq_stat_r;
            OFF_EDGE:     rd_mux_s = edge_r;
            default:      rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Edge detection, masked until the synchroniser has settled after reset.
    always_comb begin
        if (arm_r == 2'd3) begin
            event_s = (edge_r & s2_r & ~prev_r) | (~edge_r & ~s2_r & prev_r);
        end else begin
            event_s = 32'h0000_0000;
        end
    end

    // Next-state values for OUT and IRQ_STAT; a new event wins over W1C.
    always_comb begin
        out_nxt_s = out_r;
        if (wr_s && (off_s == OFF_OUT)) begin
            out_nxt_s = (out_r & ~wmask_s) | wbits_s;
        end else if (wr_s && (off_s == OFF_OUT_SET)) begin
            out_nxt_s = out_r | wbits_s;
        end else if (wr_s && (off_s == OFF_OUT_CLR)) begin
            out_nxt_s = out_r & ~wbits_s;
        end else begin
            out_nxt_s = out_r;
        end
        if (wr_s && (off_s == OFF_IRQ_STAT)) begin
            stat_nxt_s = (irq_stat_r & ~wbits_s) | event_s;
        end else begin
            stat_nxt_s = irq_stat_r | event_s;
        end
    end

    // Handshake FSM with registered ready and read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_s) begin
                        state_r     <= ST_ACK;
                        iomem_ready <= 1'b1;
                        iomem_rdata <= rd_mux_s;
                    end else begin
                        state_r     <= ST_IDLE;
                        iomem_ready <= 1'b0;
                        iomem_rdata <= 32'h0000_0000;
                    end
                end
                ST_ACK: begin
                    state_r     <= ST_IDLE;
                    iomem_ready <= 1'b0;
                    iomem_rdata <= 32'h0000_0000;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    iomem_ready <= 1'b0;
                    iomem_rdata <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Software-visible registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_r      <= 32'h0000_0000;
            oe_r       <= 32'h0000_0000;
            irq_en_r   <= 32'h0000_0000;
            irq_stat_r <= 32'h0000_0000;
            edge_r     <= 32'h0000_0000;
        end else begin
            out_r      <= out_nxt_s;
            irq_stat_r <= stat_nxt_s;
            if (wr_s && (off_s == OFF_OE)) begin
                oe_r <= (oe_r & ~wmask_s) | wbits_s;
            end
            if (wr_s && (off_s == OFF_IRQ_EN)) begin
                irq_en_r <= (irq_en_r & ~wmask_s) | wbits_s;
            end
            if (wr_s && (off_s == OFF_EDGE)) begin
                edge_r <= (edge_r & ~wmask_s) | wbits_s;
            end
        end
    end

    // Pin synchroniser, edge history, arm counter and interrupt output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_r   <= 32'h0000_0000;
            s2_r   <= 32'h0000_0000;
            prev_r <= 32'h0000_0000;
            arm_r  <= 2'd0;
            irq    <= 1'b0;
        end else begin
            s1_r   <= gpio_in;
            s2_r   <= s1_r;
            prev_r <= s2_r;
            if (arm_r != 2'd3) begin
                arm_r <= arm_r + 2'd1;
            end
            irq <= |(irq_stat_r & irq_en_r);
        end
    end

endmodule

// File: tb/tb_iomem_gpio.sv
// Self-checking bench for iomem_gpio: directed scenarios plus randomized
// register and pin-edge traffic checked against a register-level model.
module tb_iomem_gpio;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_rdata;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // Register-level model state
    logic [31:0] m_out, m_oe, m_en, m_edge, m_pins;

    iomem_gpio #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_wstrb(iomem_wstrb), .iomem_rdata(iomem_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0: return m_out;
            1: return m_oe;
            2: return m_pins;
            3: return m_en;
            5: return m_edge;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input int off, input logic [31:0] d, input logic [3:0] strb);
        logic [31:0] m = byte_mask(strb);
        case (off)
            0: m_out  = (m_out & ~m) | (d & m);
            1: m_oe   = (m_oe & ~m) | (d & m);
            3: m_en   = (m_en & ~m) | (d & m);
            5: m_edge = (m_edge & ~m) | (d & m);
            6: m_out  = m_out | (d & m);
            7: m_out  = m_out & ~(d & m);
            default: ;
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        tick(3);
        resetn = 1'b1;
        m_out = 32'h0; m_oe = 32'h0; m_en = 32'h0; m_edge = 32'h0;
    endtask

    // Drives one transaction; lat = edges until ready (0 on timeout), plus one idle cycle.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                       output logic [31:0] rd, output int lat);
        iomem_valid = 1'b1; iomem_addr = addr; iomem_wdata = wd; iomem_wstrb = strb;
        lat = 0; rd = 32'hDEAD_BEEF;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (iomem_ready) begin lat = i; rd = iomem_rdata; end
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        tick(1);
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat;
        gpio_in = 32'h0;
        do_reset();
        total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL reset_gpio_out: got %h expected 0", gpio_out); end
        total++; if (gpio_oe !== 32'h0) begin bad++; $display("FAIL reset_gpio_oe: got %h expected 0", gpio_oe); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
        total++; if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0) begin bad++; $display("FAIL reset_bus: ready %b rdata %h expected 0/0", iomem_ready, iomem_rdata); end
        for (int off = 0; off < 8; off++) begin
            bus(BASE + 32'(off * 4), 32'h0, 4'h0, rd, lat);
            total++; if (rd !== 32'h0 || lat != 1) begin bad++; $display("FAIL reset_read_%0d: got %h lat %0d expected 0 lat 1", off, rd, lat); end
        end
    endtask

    task automatic test_out_strobe();
        logic [31:0] rd; int lat;
        do_reset();
        bus(BASE, 32'hA5A5_0000, 4'b1100, rd, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL strobe_wr_lat: got %0d expected 1", lat); end
        total++; if (gpio_out !== 32'hA5A5_0000) begin bad++; $display("FAIL strobe_gpio_out: got %h expected a5a50000", gpio_out); end
        bus(BASE, 32'h0, 4'h0, rd, lat);
        total++; if (lat != 1 || rd !== 32'hA5A5_0000) begin bad++; $display("FAIL strobe_read: got %h lat %0d expected a5a50000 lat 1", rd, lat); end
        bus(BASE, 32'h1234_5678, 4'b0011, rd, lat);
        total++; if (gpio_out !== 32'hA5A5_5678) begin bad++; $display("FAIL strobe_low: got %h expected a5a55678", gpio_out); end
    endtask

    task automatic test_set_clr();
        logic [31:0] rd; int lat;
        do_reset();
        bus(BASE, 32'h0000_00FF, 4'hF, rd, lat);
        bus(BASE + 32'h18, 32'h0000_0100, 4'hF, rd, lat);
        bus(BASE + 32'h1C, 32'h0000_0001, 4'hF, rd, lat);
        total++; if (gpio_out !== 32'h0000_01FE) begin bad++; $display("FAIL setclr_gpio_out: got %h expected 000001fe", gpio_out); end
        bus(BASE + 32'h18, 32'h0, 4'h0, rd, lat);
        total++; if (rd !== 32'h0 || lat != 1) begin bad++; $display("FAIL setclr_read_set: got %h expected 0", rd); end
        bus(BASE, 32'h0, 4'h0, rd, lat);
        total++; if (rd !== 32'h0000_01FE) begin bad++; $display("FAIL setclr_read_out: got %h expected 000001fe", rd); end
    endtask

    task automatic test_irq_falling();
        logic [31:0] rd; int lat;
        gpio_in = 32'h0000_0004;
        do_reset();
        bus(BASE + 32'h14, 32'h0, 4'hF, rd, lat);
        bus(BASE + 32'h0C, 32'h0000_0004, 4'hF, rd, lat);
        tick(4);
        gpio_in = 32'h0;
        tick(1); tick(1); tick(1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL fall_irq_early: got %b expected 0", irq); end
        tick(1);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL fall_irq_latency: got %b expected 1", irq); end
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, lat);
        total++; if (rd !== 32'h0000_0004) begin bad++; $display("FAIL fall_stat: got %h expected 00000004", rd); end
        bus(BASE + 32'h10, 32'h0000_0004, 4'hF, rd, lat);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL fall_irq_clear: got %b expected 0", irq); end
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, lat);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL fall_stat_clear: got %h expected 0", rd); end
    endtask

    task automatic test_w1c_priority();
        logic [31:0] rd; int lat;
        gpio_in = 32'h0;
        do_reset();
        bus(BASE + 32'h14, 32'h1, 4'hF, rd, lat);
        bus(BASE + 32'h0C, 32'h1, 4'hF, rd, lat);
        gpio_in = 32'h1; tick(4);
        gpio_in = 32'h0; tick(4);
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, lat);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL prio_stat_pre: got %h expected 1", rd); end
        gpio_in = 32'h1;
        tick(1); tick(1);
        bus(BASE + 32'h10, 32'h1, 4'hF, rd, lat);
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, lat);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL prio_stat_kept: got %h expected 1", rd); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL prio_irq: got %b expected 1", irq); end
    endtask

    task automatic test_reset_arming();
        logic [31:0] rd; int lat;
        gpio_in = 32'hFFFF_FFFF;
        do_reset();
        bus(BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF, rd, lat);
        tick(6);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL arm_irq: got %b expected 0", irq); end
        bus(BASE + 32'h10, 32'h0, 4'h0, rd, lat);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL arm_stat: got %h expected 0", rd); end
        bus(BASE + 32'h08, 32'h0, 4'h0, rd, lat);
        total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL arm_in: got %h expected ffffffff", rd); end
    endtask

    task automatic test_reset_in_commit();
        logic [31:0] rd; int lat;
        do_reset();
        iomem_valid = 1'b1; iomem_addr = BASE; iomem_wdata = 32'h1234_5678; iomem_wstrb = 4'hF;
        resetn = 1'b0;
        tick(1);
        total++; if (iomem_ready !== 1'b0) begin bad++; $display("FAIL rstcommit_ready: got %b expected 0", iomem_ready); end
        iomem_valid = 1'b0; iomem_wstrb = 4'h0; resetn = 1'b1;
        tick(1);
        total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL rstcommit_out: got %h expected 0", gpio_out); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        iomem_valid = 1'b1; iomem_addr = BASE + 32'h20; iomem_wdata = 32'hFFFF_FFFF; iomem_wstrb = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick(1);
            total++;
            if (iomem_ready !== ((c % 2) == 0) || iomem_rdata !== 32'h0) begin
                bad++; $display("FAIL b2b_cycle%0d: ready %b rdata %h expected %0d/0", c, iomem_ready, iomem_rdata, (c % 2) == 0);
            end
        end
        tick(1);
        iomem_valid = 1'b0;
        iomem_addr = 32'h0400_0000; iomem_wstrb = 4'hF; iomem_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            total++; if (iomem_ready !== 1'b0) begin bad++; $display("FAIL unsel_ready%0d: got %b expected 0", c, iomem_ready); end
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        tick(1);
        total++; if (gpio_out !== 32'h0) begin bad++; $display("FAIL unsel_no_write: got %h expected 0", gpio_out); end
    endtask

    task automatic test_random_regs();
        logic [31:0] rd, exp, wd; int lat, sel, off; logic [3:0] strb;
        gpio_in = $urandom;
        do_reset();
        m_pins = gpio_in;
        tick(3);
        for (int n = 0; n < 60; n++) begin
            sel  = $urandom_range(0, 7);
            off  = (sel < 4) ? sel : (sel < 7) ? sel + 1 : $urandom_range(8, 63);
            wd   = $urandom;
            strb = 4'($urandom_range(0, 15));
            exp  = model_read(off);
            bus(BASE + 32'(off * 4), wd, strb, rd, lat);
            if (strb != 4'h0) model_write(off, wd, strb);
            total++; if (lat != 1 || rd !== exp) begin bad++; $display("FAIL rand_rd off%0d: got %h lat %0d expected %h lat 1", off, rd, lat, exp); end
            total++; if (gpio_out !== m_out || gpio_oe !== m_oe) begin bad++; $display("FAIL rand_pins off%0d: got %h/%h expected %h/%h", off, gpio_out, gpio_oe, m_out, m_oe); end
        end
    endtask

    task automatic test_random_edges();
        logic [31:0] rd, old_p, new_p, ev; int lat;
        old_p = $urandom;
        gpio_in = old_p;
        do_reset();
        tick(4);
        for (int n = 0; n < 12; n++) begin
            m_edge = $urandom; m_en = $urandom;
            bus(BASE + 32'h14, m_edge, 4'hF, rd, lat);
            bus(BASE + 32'h0C, m_en, 4'hF, rd, lat);
            bus(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, rd, lat);
            total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_irq_cleared%0d: got %b expected 0", n, irq); end
            new_p = $urandom;
            ev = 32'h0;
            for (int i = 0; i < 32; i++) begin
                if (m_edge[i] && !old_p[i] && new_p[i]) ev[i] = 1'b1;
                if (!m_edge[i] && old_p[i] && !new_p[i]) ev[i] = 1'b1;
            end
            gpio_in = new_p;
            tick(5);
            bus(BASE + 32'h10, 32'h0, 4'h0, rd, lat);
            total++; if (rd !== ev) begin bad++; $display("FAIL edge_stat%0d: got %h expected %h", n, rd, ev); end
            total++; if (irq !== ((ev & m_en) != 32'h0)) begin bad++; $display("FAIL edge_irq%0d: got %b expected %0d", n, irq, (ev & m_en) != 32'h0); end
            bus(BASE + 32'h08, 32'h0, 4'h0, rd, lat);
            total++; if (rd !== new_p) begin bad++; $display("FAIL edge_in%0d: got %h expected %h", n, rd, new_p); end
            old_p = new_p;
        end
    endtask

    initial begin
        resetn = 1'b0; iomem_valid = 1'b0; iomem_addr = 32'h0;
        iomem_wdata = 32'h0; iomem_wstrb = 4'h0; gpio_in = 32'h0;
        test_reset();
        test_out_strobe();
        test_set_clr();
        test_irq_falling();
        test_w1c_priority();
        test_reset_arming();
        test_reset_in_commit();
        test_back_to_back();
        test_random_regs();
        test_random_edges();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
